// File: rtl/snail_pattern_gen_pkg.sv
// Shared definitions for the snail pattern generator and its detector benches.
// State encodings, counter widths and the len-port width helper.
package snail_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_GAP   = ST_GAP,
        S_DONE  = ST_DONE
    } state_t;

    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    function automatic int len_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/snail_pattern_gen_if.sv
// Control/data bundle between a pattern source owner and the generator.
// The master side drives the request, the slave side returns the serial stream.
interface snail_pattern_gen_if
    import snail_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
);
    localparam int LW = len_w(W);

    logic             start;
    logic [W-1:0]     pattern;
    logic [LW-1:0]    len;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             d_out;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    pairs;

    modport master (
        output start, pattern, len, reps, gap,
        input  d_out, valid, busy, done, pairs
    );

    modport slave (
        input  start, pattern, len, reps, gap,
        output d_out, valid, busy, done, pairs
    );

endinterface

// File: rtl/snail_pattern_gen_shifter.sv
// Parallel-load MSB-first shift register with remaining-bit counter.
// bit_o is registered and reads 0 in any cycle without a load or shift.
module snail_shifter
    import snail_pkg::*;
#(
    parameter int W = 16,
    localparam int LW = len_w(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  pat_i,
    input  logic [LW-1:0] len_i,
    output logic          bit_o,
    output logic          nxt_o,
    output logic          last
);

    logic [W-1:0]  sr_q, sr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          bit_q, bit_d;
    logic [W-1:0]  aligned;

    // Bit len-1 moved up to the MSB so every pattern leaves from the top.
    assign aligned = pat_i << (W - int'(len_i));

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        bit_d = 1'b0;
        nxt_o = sr_q[W-1];
        if (load) begin
            nxt_o = aligned[W-1];
            bit_d = aligned[W-1];
            sr_d  = {aligned[W-2:0], 1'b0};
            cnt_d = len_i - 1'b1;
        end else if (shift) begin
            bit_d = sr_q[W-1];
            sr_d  = {sr_q[W-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
            bit_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
        end
    end

    assign bit_o = bit_q;
    assign last  = (cnt_q == '0);

endmodule

// File: rtl/snail_pattern_gen.sv
// Serial pattern transmitter with repeat/gap control and a "11" pair counter.
// All outputs come straight from registers.
module snail_pattern_gen
    import snail_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                rst,
    snail_pattern_gen_if.slave  bus
);

    localparam int LW = len_w(W);
    localparam logic [LW-1:0] W_LEN = LW'(W);

    state_t           state_q, state_d;
    logic [W-1:0]     pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [CW-1:0]    pairs_q, pairs_d;
    logic             prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ld, sh, nxt, last, bit_s, idle;
    logic [LW-1:0]    len_eff, ld_len;
    logic [W-1:0]     ld_pat;

    assign len_eff = (bus.len == '0 || bus.len > W_LEN)
                   ? W_LEN : bus.len;
    assign idle    = (state_q == S_IDLE);
    assign ld_pat  = idle ? bus.pattern : pat_q;
    assign ld_len  = idle ? len_eff : len_q;

    snail_shifter #(.W(W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (ld),
        .shift (sh),
        .pat_i (ld_pat),
        .len_i (ld_len),
        .bit_o (bit_s),
        .nxt_o (nxt),
        .last  (last)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        pairs_d = pairs_q;
        prev_d  = prev_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ld      = 1'b0;
        sh      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pat_d   = bus.pattern;
                    len_d   = len_eff;
                    rep_d   = bus.reps;
                    gap_d   = bus.gap;
                    pairs_d = '0;
                    prev_d  = 1'b0;
                    ld      = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!last) begin
                    sh      = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d  = rep_q - 1'b1;
                    busy_d = 1'b1;
                    if (gap_q != '0) begin
                        gcnt_d  = gap_q - 1'b1;
                        prev_d  = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        ld      = 1'b1;
                        valid_d = 1'b1;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                prev_d = 1'b0;
                if (gcnt_q == '0) begin
                    ld      = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // prev_d already holds the flag in force for the bit being emitted.
        if (ld || sh) begin
            if (nxt && prev_d && pairs_d != '1)
                pairs_d = pairs_d + 1'b1;
            prev_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            pairs_q <= '0;
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            pairs_q <= pairs_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.d_out = bit_s;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.pairs = pairs_q;

endmodule

// File: tb/tb_snail_pattern_gen.sv
// Directed bench for snail_pattern_gen: reset, single shot, repeats,
// length clamp, pair saturation and start-while-busy with a "11" detector.
module tb_snail_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    snail_pattern_gen_if #(.W(16), .CW(8)) bus ();

    snail_pattern_gen #(.W(16), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {valid, d_out, busy, done}
    function automatic logic [3:0] obs();
        return {bus.valid, bus.d_out, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then scramble inputs (don't-care afterwards).
    task automatic launch(input logic [15:0] p, input logic [4:0] l,
                          input logic [3:0] r, input logic [3:0] g);
        bus.pattern = p;
        bus.len     = l;
        bus.reps    = r;
        bus.gap     = g;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.pattern = ~p;
        bus.len     = l + 5'd3;
        bus.reps    = ~r;
        bus.gap     = ~g;
    endtask

    task automatic test_reset();
        logic [3:0] o;
        bus.start = 1'b0; bus.pattern = '0; bus.len = '0;
        bus.reps = '0; bus.gap = '0;
        rst = 1'b1;
        tick(); tick();
        o = obs();
        vectors++;
        if (o !== 4'b0000 || bus.pairs !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got o=%b pairs=%0d, want 0000/0",
                     o, bus.pairs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] b;
        b = 8'b1011_0111;
        launch(16'h00B7, 5'd8, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs() !== {1'b1, b[7-i], 2'b10}) begin
                errors++;
                $display("FAIL single_bit%0d: got %b, want %b",
                         i, obs(), {1'b1, b[7-i], 2'b10});
            end
            tick();
        end
        vectors++;
        if (obs() !== 4'b0001 || bus.pairs !== 8'd3) begin
            errors++;
            $display("FAIL single_done: got %b pairs=%0d, want 0001/3",
                     obs(), bus.pairs);
        end
        tick();
        vectors++;
        if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL single_done_pulse: got %b, want 0000", obs());
        end
        tick(); tick(); tick();
        vectors++;
        if (bus.pairs !== 8'd3) begin
            errors++;
            $display("FAIL single_pairs_hold: got %0d, want 3", bus.pairs);
        end
    endtask

    task automatic test_reset_midstream();
        logic [2:0] b;
        b = 3'b101;
        launch(16'h00B3, 5'd8, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs() !== {1'b1, b[2-i], 2'b10}) begin
                errors++;
                $display("FAIL midrst_bit%0d: got %b, want %b",
                         i, obs(), {1'b1, b[2-i], 2'b10});
            end
            if (i < 2) tick();
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (obs() !== 4'b0000 || bus.pairs !== 8'd0) begin
            errors++;
            $display("FAIL midrst_clear: got %b pairs=%0d, want 0000/0",
                     obs(), bus.pairs);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (obs() !== 4'b0000) begin
                errors++;
                $display("FAIL midrst_quiet%0d: got %b, want 0000",
                         i, obs());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp[$];
        exp = '{4'b1110, 4'b1010, 4'b1110, 4'b1110, 4'b1010,
                4'b1110, 4'b0001, 4'b0000};
        launch(16'h0005, 5'd3, 4'd1, 4'd0);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL b2b_cyc%0d: got %b, want %b",
                         i, obs(), exp[i]);
            end
            tick();
        end
        vectors++;
        if (bus.pairs !== 8'd1) begin
            errors++;
            $display("FAIL b2b_pairs: got %0d, want 1", bus.pairs);
        end
    endtask

    task automatic test_gap();
        logic [3:0] exp[$];
        exp = '{4'b1110, 4'b1010, 4'b1110, 4'b0010, 4'b0010,
                4'b1110, 4'b1010, 4'b1110, 4'b0001, 4'b0000};
        launch(16'h0005, 5'd3, 4'd1, 4'd2);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL gap_cyc%0d: got %b, want %b",
                         i, obs(), exp[i]);
            end
            tick();
        end
        vectors++;
        if (bus.pairs !== 8'd0) begin
            errors++;
            $display("FAIL gap_pairs: got %0d, want 0", bus.pairs);
        end
    endtask

    task automatic test_len_clamp();
        logic [15:0] p;
        p = 16'h8001;
        launch(p, 5'd20, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs() !== {1'b1, p[15-i], 2'b10}) begin
                errors++;
                $display("FAIL clamp_bit%0d: got %b, want %b",
                         i, obs(), {1'b1, p[15-i], 2'b10});
            end
            tick();
        end
        vectors++;
        if (obs() !== 4'b0001) begin
            errors++;
            $display("FAIL clamp_done: got %b, want 0001", obs());
        end
        tick();
    endtask

    task automatic test_saturation();
        int want;
        launch(16'hFFFF, 5'd0, 4'd15, 4'd0);
        for (int i = 0; i < 256; i++) begin
            want = (i > 255) ? 255 : i;
            vectors++;
            if (obs() !== 4'b1110 || bus.pairs !== want[7:0]) begin
                errors++;
                $display("FAIL sat_cyc%0d: got %b pairs=%0d, want 1110/%0d",
                         i, obs(), bus.pairs, want);
            end
            tick();
        end
        vectors++;
        if (obs() !== 4'b0001 || bus.pairs !== 8'd255) begin
            errors++;
            $display("FAIL sat_done: got %b pairs=%0d, want 0001/255",
                     obs(), bus.pairs);
        end
        tick();
    endtask

    task automatic test_start_busy();
        logic [3:0] exp[$];
        logic [7:0] b;
        logic       det_prev;
        int         det_cnt;
        b = 8'b1011_0111;
        exp = {};
        for (int i = 0; i < 8; i++) exp.push_back({1'b1, b[7-i], 2'b10});
        exp.push_back(4'b0010);
        for (int i = 0; i < 8; i++) exp.push_back({1'b1, b[7-i], 2'b10});
        exp.push_back(4'b0001);
        exp.push_back(4'b0000);
        exp.push_back(4'b0000);
        det_prev = 1'b0;
        det_cnt  = 0;
        launch(16'h00B7, 5'd8, 4'd1, 4'd1);
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (obs() !== exp[i]) begin
                errors++;
                $display("FAIL busy_cyc%0d: got %b, want %b",
                         i, obs(), exp[i]);
            end
            if (bus.d_out && det_prev) det_cnt++;
            det_prev = bus.d_out;
            bus.start = (i == 3 || i == 17);
            if (bus.start) begin
                bus.pattern = 16'hFFFF;
                bus.len     = 5'd4;
                bus.reps    = 4'd0;
                bus.gap     = 4'd0;
            end
            tick();
        end
        bus.start = 1'b0;
        vectors++;
        if (det_cnt != 6 || bus.pairs !== 8'd6) begin
            errors++;
            $display("FAIL busy_pairs: det=%0d pairs=%0d, want 6/6",
                     det_cnt, bus.pairs);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_midstream();
        test_back_to_back();
        test_gap();
        test_len_clamp();
        test_saturation();
        test_start_busy();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
